// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial two's-complement adder/subtractor behind a start/busy/done handshake
module serial_addsub #(
  parameter int WIDTH = 10,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N = (WIDTH + SLICE - 1) / SLICE;
  localparam int LB = WIDTH - (N - 1) * SLICE;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLAST = KW'(N - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, bx;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic [KW-1:0] k_q, k_d;
  logic [SLICE:0] dsum;
  logic last;
  assign bx = sub ? ~B : B;
  assign last = k_q == KLAST;
  assign dsum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + (SLICE+1)'(carry_q);
  // Operands shift down one digit per cycle; result digits enter from the top, and the
  // final digit shifts by only its live width so digit 0 lands at bit 0.
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    k_d = k_q;
    if (state_q == RUN) begin
      a_d = a_q >> SLICE;
      b_d = b_q >> SLICE;
      sum_d = WIDTH'({dsum[SLICE-1:0], sum_q} >> (last ? LB : SLICE));
      carry_d = dsum[SLICE];
      k_d = last ? '0 : k_q + 1'b1;
      if (last) begin
        cout_d = dsum[LB];
        ovf_d = (amsb_q == bmsb_q) && (sum_d[WIDTH-1] != amsb_q);
        state_d = DONE;
      end
    end else if (start) begin
      a_d = A;
      b_d = bx;
      carry_d = sub;
      amsb_d = A[WIDTH-1];
      bmsb_d = bx[WIDTH-1];
      k_d = '0;
      state_d = RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      k_q <= k_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign Sum = sum_q;
  assign cout = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed checks on the 10/4 configuration plus a reference-model sweep of other widths
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst, start, sub, busy, done, cout, overflow;
  logic [9:0] A, B, Sum;
  logic go = 1'b0;
  logic [3:0] sw_done = '0;
  int n_pass = 0, n_total = 0;
  always #5 clk = ~clk;
  serial_addsub #(.WIDTH(10), .SLICE(4)) dut (
    .clk(clk), .reset(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .Sum(Sum), .cout(cout), .overflow(overflow)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic op(input string tag, input logic [9:0] a, input logic [9:0] b, input logic s,
                    input logic [9:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 20 && !done; c++) begin
      if (busy) n++;
      @(negedge clk);
    end
    check({tag, ".busy_cycles"}, 32'(n), 32'd3);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".sum"}, 32'(Sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".ovf"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".sum_hold"}, 32'(Sum), 32'(es));
  endtask
  localparam int WS[4] = '{16, 10, 8, 7};
  localparam int SS[4] = '{4, 3, 8, 1};
  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int W = WS[g];
    localparam int S = SS[g];
    localparam int N = (W + S - 1) / S;
    logic st, sb_i, bz, dn, co, ov;
    logic [W-1:0] a, b, sm;
    serial_addsub #(.WIDTH(W), .SLICE(S)) u (
      .clk(clk), .reset(rst), .start(st), .sub(sb_i), .A(a), .B(b),
      .busy(bz), .done(dn), .Sum(sm), .cout(co), .overflow(ov)
    );
    initial begin
      int sa, sbv, r, ua, ub, n;
      logic ec, eo;
      logic [W-1:0] es;
      st = 1'b0; sb_i = 1'b0; a = '0; b = '0;
      wait (go);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); sb_i = 1'($urandom); st = 1'b1;
        sa = $signed(a); sbv = $signed(b); ua = int'(a); ub = int'(b);
        r = sb_i ? sa - sbv : sa + sbv;
        es = W'(r);
        eo = r > (2 ** (W - 1)) - 1 || r < -(2 ** (W - 1));
        ec = sb_i ? ua >= ub : ua + ub >= 2 ** W;
        @(posedge clk);
        #1 st = 1'b0;
        n = 0;
        @(negedge clk);
        for (int c = 0; c < 4 * N + 8 && !dn; c++) begin
          n++;
          @(negedge clk);
        end
        check($sformatf("sweep%0d.lat", g), 32'(n), 32'(N));
        check($sformatf("sweep%0d.sum a=%0h b=%0h s=%0d", g, a, b, sb_i), 32'(sm), 32'(es));
        check($sformatf("sweep%0d.cout", g), 32'(co), 32'(ec));
        check($sformatf("sweep%0d.ovf", g), 32'(ov), 32'(eo));
      end
      sw_done[g] = 1'b1;
    end
  end
  logic [9:0] ba[3] = '{10'h001, 10'h100, 10'h010};
  logic [9:0] bb[3] = '{10'h002, 10'h0FF, 10'h020};
  logic bsub[3] = '{1'b0, 1'b0, 1'b1};
  logic [9:0] bexp[3] = '{10'h003, 10'h1FF, 10'h3F0};
  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.sum", 32'(Sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    op("add3_5", 10'h003, 10'h005, 1'b0, 10'h008, 1'b0, 1'b0);
    op("addm1_1", 10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1, 1'b0);
    op("add511_1", 10'h1FF, 10'h001, 1'b0, 10'h200, 1'b0, 1'b1);
    op("sub5_7", 10'h005, 10'h007, 1'b1, 10'h3FE, 1'b0, 1'b0);
    op("subm512_1", 10'h200, 10'h001, 1'b1, 10'h1FF, 1'b1, 1'b1);
    op("sub0_0", 10'h000, 10'h000, 1'b1, 10'h000, 1'b1, 1'b0);
    op("addm512_m512", 10'h200, 10'h200, 1'b0, 10'h000, 1'b1, 1'b1);
    @(negedge clk);
    A = ba[0]; B = bb[0]; sub = bsub[0]; start = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (t % 4 == 0) begin
        check($sformatf("b2b%0d.done", t), 32'(done), 32'd1);
        check($sformatf("b2b%0d.sum", t), 32'(Sum), 32'(bexp[t/4-1]));
        if (t < 12) begin
          A = ba[t/4]; B = bb[t/4]; sub = bsub[t/4];
        end else start = 1'b0;
      end else begin
        check($sformatf("b2b%0d.nodone", t), 32'(done), 32'd0);
        A = 10'h155 ^ 10'(t); B = 10'h2AA; sub = t[0];
      end
    end
    @(negedge clk);
    A = 10'h0AA; B = 10'h055; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.sum", 32'(Sum), 32'd0);
    check("abort.cout", 32'(cout), 32'd0);
    check("abort.ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort.quiet", 32'(seen), 32'd0);
    op("fresh", 10'h0AA, 10'h055, 1'b0, 10'h0FF, 1'b0, 1'b0);
    go = 1'b1;
    wait (&sw_done);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
